// File: rtl/mux_arb_n_pkg.sv
// Shared encodings and default sizing for the N-way arbitrating mux.
package mux_arb_n_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 4;
endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Combinational rotating-priority picker: first requester after ptr wins.
module rr_arbiter
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any_grant
);
    logic [SELW-1:0] idx;

    // NCH is a power of two, so SELW-bit truncation gives the modulo wrap;
    // offset NCH lands back on ptr itself as the lowest priority.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = ptr + SELW'(i);
            if (!any_grant && req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_n.sv
// NCH-channel mux with fixed or round-robin select into a one-entry output register.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = $clog2(DEF_NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);
    logic [WIDTH-1:0] ch_data [NCH];
    logic [SELW-1:0]  ptr, rr_gnt, gnt;
    logic             rr_any, any, can_load, xfer;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_gnt),
        .any_grant (rr_any)
    );

    // Grant is purely combinational so mode/sel changes act in the same cycle.
    always_comb begin
        gnt = rr_gnt;
        any = rr_any;
        if (mode == MODE_FIXED) begin
            gnt = sel;
            any = in_valid[sel];
        end
        can_load = !out_valid || out_ready;
        xfer     = any && can_load && !rst;
        in_ready = xfer ? (NCH'(1) << gnt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[gnt];
            out_ch    <= gnt;
            if (mode == MODE_RR)
                ptr <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: vector table plus hand-written stall and reset sequences.
module tb_mux_arb_n;
    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    typedef struct packed {
        logic            mode;
        logic [SELW-1:0] sel;
        logic [NCH-1:0]  valid;
        logic            ordy;
        logic [NCH-1:0]  erdy;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  ch;
    } word_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    logic [WIDTH-1:0] chdat [NCH];
    word_t            sb [$];
    vec_t             tbl [$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [SELW-1:0]  exp_ch;

    always #5 clk = ~clk;
    assign in_data = {chdat[3], chdat[2], chdat[1], chdat[0]};

    mux_arb_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm);
        check({nm, " out_valid"}, 64'(out_valid), 64'(exp_valid));
        check({nm, " out_data"},  64'(out_data),  64'(exp_data));
        check({nm, " out_ch"},    64'(out_ch),    64'(exp_ch));
    endtask

    // Called at posedge+1; drives one cycle and checks in_ready then the registered result.
    task automatic step(input logic m, input logic [SELW-1:0] s, input logic [NCH-1:0] v,
                        input logic ordy, input logic [NCH-1:0] erdy, input string nm);
        word_t w;
        mode = m; sel = s; in_valid = v; out_ready = ordy;
        @(negedge clk);
        check({nm, " in_ready"}, 64'(in_ready), 64'(erdy));
        if (erdy != '0) begin
            for (int i = 0; i < NCH; i++)
                if (erdy[i]) begin
                    w.ch   = SELW'(i);
                    w.data = chdat[i];
                end
            sb.push_back(w);
        end
        @(posedge clk); #1;
        if (erdy != '0) begin
            w = sb.pop_front();
            exp_valid = 1'b1;
            exp_data  = w.data;
            exp_ch    = w.ch;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        check_out(nm);
    endtask

    task automatic do_reset(input logic [NCH-1:0] v, input logic ordy, input string nm);
        rst = 1'b1; mode = 1'b1; sel = '0; in_valid = v; out_ready = ordy;
        @(negedge clk);
        check({nm, " in_ready during rst"}, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_valid = 1'b0; exp_data = '0; exp_ch = '0;
        check_out(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chdat[0] = 32'h0BAD_0000;
        chdat[1] = 32'h1111_1111;
        chdat[2] = 32'hA5A5_A5A5;
        chdat[3] = 32'h3C3C_3C3C;
        exp_valid = 1'b0; exp_data = '0; exp_ch = '0;

        // mode, sel, in_valid, out_ready, expected in_ready (ptr traced by hand)
        tbl.push_back('{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100}); // fixed sel=2
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001}); // rr from reset ptr=3
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001});
        tbl.push_back('{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000}); // ptr -> 3
        tbl.push_back('{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010}); // wrap skips ch0
        tbl.push_back('{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100});
        tbl.push_back('{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000}); // drain, out_valid falls
        tbl.push_back('{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000}); // out_ready while empty
        tbl.push_back('{1'b0, 2'd3, 4'b0111, 1'b0, 4'b0000}); // fixed, sel idle

        do_reset(4'b1111, 1'b1, "reset");
        foreach (tbl[k])
            step(tbl[k].mode, tbl[k].sel, tbl[k].valid, tbl[k].ordy, tbl[k].erdy,
                 $sformatf("vec%0d", k));

        // Stall: held word survives five blocked cycles with changing inputs.
        chdat[0] = 32'h1234_5678;
        step(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, "load 12345678");
        for (int c = 0; c < 5; c++) begin
            chdat[c % NCH] = $urandom;
            step(1'(c % 2), 2'(c), 4'b1111, 1'b0, 4'b0000, $sformatf("stall%0d", c));
        end
        step(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, "unstall load");

        // Fixed select on an idle channel, then switch sel mid-stream.
        step(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, "sel1 idle consume");
        step(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, "sel1 idle again");
        step(1'b0, 2'd0, 4'b1101, 1'b1, 4'b0001, "sel0 switch");

        // Reset while a word is held and stalled; first rr grant after is ch0.
        step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, "hold before rst");
        do_reset(4'b1111, 1'b0, "mid rst");
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr after rst");
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr after rst 2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
